// File: rtl/visit_bitmap_rmw.sv
// visit_bitmap_rmw: visited-cell bitmap held in a simple dual-port block RAM.
// Each accepted position reports whether its cell was already marked, then
// marks it through a read-modify-write pipeline that accepts one lookup per
// cycle. After reset the RAM is swept to zero and the origin cell is pre-marked.
`timescale 1ns/1ps
module visit_bitmap_rmw #(
  parameter int POSTION_WIDTH = 8,
  parameter int WORD_WIDTH    = 32,
  parameter int ORIGIN_X      = 2 ** (POSTION_WIDTH - 1),
  parameter int ORIGIN_Y      = 2 ** (POSTION_WIDTH - 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pos_change,
  input  logic [POSTION_WIDTH-1:0] pos_x,
  input  logic [POSTION_WIDTH-1:0] pos_y,
  output logic                     init_done,
  output logic                     lookup_valid,
  output logic                     lookup_already_visited,
  output logic                     drop_error
);

  localparam int IDX_W  = 2 * POSTION_WIDTH;
  localparam int BIT_W  = $clog2(WORD_WIDTH);
  localparam int ADDR_W = IDX_W - BIT_W;
  localparam int DEPTH  = 2 ** ADDR_W;

  localparam logic [IDX_W-1:0]  ORIGIN_IDX  = {POSTION_WIDTH'(ORIGIN_Y), POSTION_WIDTH'(ORIGIN_X)};
  localparam logic [ADDR_W-1:0] ORIGIN_WORD = ORIGIN_IDX[IDX_W-1:BIT_W];
  localparam logic [BIT_W-1:0]  ORIGIN_BIT  = ORIGIN_IDX[BIT_W-1:0];
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t                  state;
  logic [ADDR_W-1:0]       sweep_addr;

  // Bitmap storage; no reset, its contents come only from the sweep.
  logic [WORD_WIDTH-1:0]   mem [DEPTH];
  logic [WORD_WIDTH-1:0]   rd_data;

  // Lookup in flight whose RAM read data is available this cycle.
  logic                    s1_valid;
  logic [ADDR_W-1:0]       s1_addr;
  logic [BIT_W-1:0]        s1_bit;

  // Copy of the write that landed at the same edge as s1's RAM read.
  logic                    last_wr_valid;
  logic [ADDR_W-1:0]       last_wr_addr;
  logic [WORD_WIDTH-1:0]   last_wr_data;

  logic [IDX_W-1:0]        idx;
  logic                    accept;
  logic [WORD_WIDTH-1:0]   cur_word;
  logic [WORD_WIDTH-1:0]   merged_word;
  logic                    already;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [WORD_WIDTH-1:0]   wr_data;

  assign idx    = {pos_y, pos_x};
  assign accept = pos_change & init_done;

  // Forward the previous write when it targets the word just read, then merge in the new bit.
  always_comb begin
    cur_word = rd_data;
    if (last_wr_valid && (last_wr_addr == s1_addr)) begin
      cur_word = last_wr_data;
    end else begin
      cur_word = rd_data;
    end
    already     = cur_word[s1_bit];
    merged_word = cur_word | (WORD_WIDTH'(1) << s1_bit);
  end

  // Write-port mux: sweep writes during CLEAR, pipeline write-backs during RUN.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (reset) begin
      wr_en = 1'b0;
    end else if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = sweep_addr;
      if (sweep_addr == ORIGIN_WORD) begin
        wr_data = WORD_WIDTH'(1) << ORIGIN_BIT;
      end else begin
        wr_data = '0;
      end
    end else begin
      wr_en   = s1_valid;
      wr_addr = s1_addr;
      wr_data = merged_word;
    end
  end

  // RAM write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // RAM registered read port, addressed straight from the incoming position.
  always_ff @(posedge clk) begin
    rd_data <= mem[idx[IDX_W-1:BIT_W]];
  end

  // Control FSM: sweep the RAM in CLEAR, then stay in RUN until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR;
      sweep_addr <= '0;
      init_done  <= 1'b0;
      drop_error <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          sweep_addr <= sweep_addr + ADDR_W'(1);
          if (sweep_addr == LAST_ADDR) begin
            state <= RUN;
          end
        end
        RUN: begin
          init_done <= 1'b1;
        end
        default: begin
          state      <= CLEAR;
          sweep_addr <= '0;
        end
      endcase
      if (pos_change && !init_done) begin
        drop_error <= 1'b1;
      end
    end
  end

  // Lookup pipeline and registered results.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid               <= 1'b0;
      last_wr_valid          <= 1'b0;
      lookup_valid           <= 1'b0;
      lookup_already_visited <= 1'b0;
    end else begin
      s1_valid               <= accept;
      s1_addr                <= idx[IDX_W-1:BIT_W];
      s1_bit                 <= idx[BIT_W-1:0];
      last_wr_valid          <= s1_valid;
      last_wr_addr           <= s1_addr;
      last_wr_data           <= merged_word;
      lookup_valid           <= s1_valid;
      lookup_already_visited <= s1_valid & already;
    end
  end

endmodule
